// File: rtl/serial_sub_pkg.sv
// Shared types and helpers for the bit-serial subtractor controller.
package serial_sub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Ceiling log2, never below 1 so a 2-bit operand still gets a 1-bit counter.
    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/full_sub_cell.sv
// One-bit full subtractor built from two half subtractors and an OR of their borrows.
module full_sub_cell (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    logic d1;
    logic b1;
    logic b2;

    half_sub_cell u_hs0 (
        .a    (a),
        .b    (b),
        .d    (d1),
        .bout (b1)
    );

    half_sub_cell u_hs1 (
        .a    (d1),
        .b    (bin),
        .d    (d),
        .bout (b2)
    );

    assign bout = b1 | b2;

endmodule

// File: rtl/half_sub_cell.sv
// One-bit half subtractor: d = a - b, bout set when a borrow is needed.
module half_sub_cell (
    input  logic a,
    input  logic b,
    output logic d,
    output logic bout
);

    assign d    = a ^ b;
    assign bout = ~a & b;

endmodule

// File: rtl/serial_sub_ctrl.sv
// Bit-serial N-bit subtractor: latches operands on start, feeds one full-subtractor
// cell LSB-first, then presents the difference and final borrow with a done pulse.
module serial_sub_ctrl
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out
);

    localparam int CW = clog2(WIDTH);

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] opa_reg, opa_next;
    logic [WIDTH-1:0] opb_reg, opb_next;
    logic [WIDTH-1:0] result_reg, result_next;
    logic [WIDTH-1:0] diff_reg, diff_next;
    logic [CW-1:0]    cnt_reg, cnt_next;
    logic             borrow_reg, borrow_next;
    logic             borrow_out_reg, borrow_out_next;
    logic             busy_reg, busy_next;
    logic             done_reg, done_next;
    logic             cell_d;
    logic             cell_bout;

    full_sub_cell u_cell (
        .a    (opa_reg[0]),
        .b    (opb_reg[0]),
        .bin  (borrow_reg),
        .d    (cell_d),
        .bout (cell_bout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            opa_reg        <= '0;
            opb_reg        <= '0;
            result_reg     <= '0;
            diff_reg       <= '0;
            cnt_reg        <= '0;
            borrow_reg     <= 1'b0;
            borrow_out_reg <= 1'b0;
            busy_reg       <= 1'b0;
            done_reg       <= 1'b0;
        end else begin
            state_reg      <= state_next;
            opa_reg        <= opa_next;
            opb_reg        <= opb_next;
            result_reg     <= result_next;
            diff_reg       <= diff_next;
            cnt_reg        <= cnt_next;
            borrow_reg     <= borrow_next;
            borrow_out_reg <= borrow_out_next;
            busy_reg       <= busy_next;
            done_reg       <= done_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        opa_next        = opa_reg;
        opb_next        = opb_reg;
        result_next     = result_reg;
        diff_next       = diff_reg;
        cnt_next        = cnt_reg;
        borrow_next     = borrow_reg;
        borrow_out_next = borrow_out_reg;

        case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next  = RUN;
                    opa_next    = a;
                    opb_next    = b;
                    borrow_next = 1'b0;
                    cnt_next    = '0;
                    result_next = '0;
                end
            end
            RUN: begin
                result_next = {cell_d, result_reg[WIDTH-1:1]};
                opa_next    = opa_reg >> 1;
                opb_next    = opb_reg >> 1;
                borrow_next = cell_bout;
                if (cnt_reg == CW'(WIDTH - 1)) begin
                    // Last bit: publish the completed word and its borrow together.
                    state_next      = DONE;
                    diff_next       = result_next;
                    borrow_out_next = cell_bout;
                end else begin
                    cnt_next = cnt_reg + CW'(1);
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        busy_next = (state_next == RUN);
        done_next = (state_next == DONE);
    end

    assign busy       = busy_reg;
    assign done       = done_reg;
    assign diff       = diff_reg;
    assign borrow_out = borrow_out_reg;

endmodule

// File: tb/tb_serial_sub_ctrl.sv
// Scoreboard bench for serial_sub_ctrl at WIDTH=8 and WIDTH=4 with a cycle-count reference model.
module tb_serial_sub_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start_v [2];
    logic [31:0] a_v [2];
    logic [31:0] b_v [2];
    int          cyc = 0;
    int          checks = 0;
    int          failures = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int inst, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s inst=%0d cyc=%0d got=%0d expected=%0d", nm, inst, cyc, act, exp);
        end
    endtask

    for (genvar gi = 0; gi < 2; gi++) begin : g_dut
        localparam int W = (gi == 0) ? 8 : 4;
        localparam logic [31:0] MASK = (32'd1 << W) - 32'd1;

        logic         busy;
        logic         done;
        logic [W-1:0] diff;
        logic         borrow_out;

        int q_d[$];
        int q_b[$];
        int q_c[$];
        int free_c = 0;
        int held_d = 0;
        int held_b = 0;
        bit exp_done;
        bit exp_busy;

        serial_sub_ctrl #(.WIDTH(W)) u_dut (
            .clk        (clk),
            .rst_n      (rst_n),
            .start      (start_v[gi]),
            .a          (a_v[gi][W-1:0]),
            .b          (b_v[gi][W-1:0]),
            .busy       (busy),
            .done       (done),
            .diff       (diff),
            .borrow_out (borrow_out)
        );

        // Reference: an accepted op finishes W edges later; the block is free again at W+2.
        always @(posedge clk) begin
            if (rst_n && start_v[gi] && cyc >= free_c) begin
                int av;
                int bv;
                av = int'(a_v[gi] & MASK);
                bv = int'(b_v[gi] & MASK);
                q_d.push_back((av - bv) & int'(MASK));
                q_b.push_back((av < bv) ? 1 : 0);
                q_c.push_back(cyc + W + 1);
                free_c = cyc + W + 2;
            end
        end

        always @(negedge clk) begin
            if (!rst_n) begin
                chk("rst_busy", gi, int'(busy), 0);
                chk("rst_done", gi, int'(done), 0);
                chk("rst_diff", gi, int'(diff), 0);
                chk("rst_borrow", gi, int'(borrow_out), 0);
                q_d.delete();
                q_b.delete();
                q_c.delete();
                held_d = 0;
                held_b = 0;
                free_c = 0;
            end else begin
                exp_done = (q_c.size() > 0) && (cyc == q_c[0]);
                exp_busy = (q_c.size() > 0) && (cyc < q_c[0]);
                if (exp_done) begin
                    held_d = q_d.pop_front();
                    held_b = q_b.pop_front();
                    void'(q_c.pop_front());
                end
                chk("busy", gi, int'(busy), int'(exp_busy));
                chk("done", gi, int'(done), int'(exp_done));
                chk("diff", gi, int'(diff), held_d);
                chk("borrow_out", gi, int'(borrow_out), held_b);
            end
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic op(input int inst, input int av, input int bv);
        int w;
        w = (inst == 0) ? 8 : 4;
        step();
        start_v[inst] = 1'b1;
        a_v[inst] = av;
        b_v[inst] = bv;
        step();
        start_v[inst] = 1'b0;
        repeat (w) begin
            a_v[inst] = $urandom;
            b_v[inst] = $urandom;
            step();
        end
    endtask

    initial begin
        rst_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            start_v[i] = 1'b0;
            a_v[i] = '0;
            b_v[i] = '0;
        end
        repeat (3) step();
        rst_n = 1'b1;
        repeat (2) step();

        op(0, 200, 55);
        op(0, 5, 9);
        op(0, 77, 77);
        op(0, 0, 255);

        // Start pulses during RUN must be ignored.
        step();
        start_v[0] = 1'b1;
        a_v[0] = 40;
        b_v[0] = 13;
        step();
        for (int k = 1; k <= 8; k++) begin
            start_v[0] = (k == 3 || k == 6);
            a_v[0] = $urandom;
            b_v[0] = $urandom;
            step();
        end
        start_v[0] = 1'b0;
        repeat (4) step();

        // Continuous start: back-to-back accepts at full throughput.
        start_v[0] = 1'b1;
        repeat (30) begin
            a_v[0] = $urandom;
            b_v[0] = $urandom;
            step();
        end
        start_v[0] = 1'b0;
        repeat (12) step();

        // Reset in the middle of RUN discards the op.
        start_v[0] = 1'b1;
        a_v[0] = 123;
        b_v[0] = 45;
        step();
        start_v[0] = 1'b0;
        repeat (3) step();
        rst_n = 1'b0;
        repeat (2) step();
        rst_n = 1'b1;
        op(0, 10, 3);

        repeat (40) op(0, int'($urandom_range(0, 255)), int'($urandom_range(0, 255)));
        op(0, 255, 0);
        op(0, 0, 0);

        for (int i = 0; i < 16; i++) begin
            for (int j = 0; j < 16; j++) begin
                op(1, i, j);
            end
        end

        repeat (12) step();
        chk("drained", 0, g_dut[0].q_c.size(), 0);
        chk("drained", 1, g_dut[1].q_c.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/serial_sub_ctrl.md
# serial_sub_ctrl

Bit-serial N-bit subtractor controller. It latches two operands on a start request and drives a single one-bit full-subtractor cell LSB-first, one bit per clock. It accumulates the difference in a shift register, then reports the result and final borrow with a one-cycle done pulse. It is the sequencing layer above the team's half-subtractor cell, used where area matters more than latency.

## Interface
- WIDTH, 8, operand/result width in bits; legal range 2..32.
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  request; sampled only in IDLE.
- a  in  WIDTH  minuend; sampled on the accepting edge only.
- b  in  WIDTH  subtrahend; sampled on the accepting edge only.
- busy  out  1  high while bits are being processed (RUN).
- done  out  1  one-cycle pulse; diff/borrow_out valid from this cycle.
- diff  out  WIDTH  (a − b) mod 2^WIDTH.
- borrow_out  out  1  1 iff a < b (unsigned).

## Operation
- States: IDLE, RUN, DONE.
  - IDLE→RUN when start=1.
  - RUN→DONE when the bit counter reaches WIDTH−1 and that bit is processed.
  - DONE→IDLE unconditionally.
- Accepting edge (IDLE, start=1):
  - opa←a, opb←b; borrow flop←0; counter←0; result shift register←0.
  - diff and borrow_out are not cleared until the next RUN writes over them.
- Each RUN edge:
  - Cell inputs are opa[0], opb[0], borrow flop.
  - Cell outputs: d = opa[0]^opb[0]^bin; bout = (~opa[0]&opb[0]) | (~(opa[0]^opb[0])&bin).
  - result←{d, result[WIDTH−1:1]}; opa, opb shift right by 1; borrow flop←bout; counter+1.
- On the RUN→DONE edge: diff←final result; borrow_out←final bout.
- start in RUN or DONE is ignored, with no queuing. start held high through DONE is accepted in the following IDLE cycle.
- Outputs hold their last result indefinitely in IDLE.
- Counter width is clog2(WIDTH). Counter wrap never occurs because it is reset on every accept.

## Timing
- Reset values: busy=0, done=0, diff=0, borrow_out=0, state=IDLE, all internal registers 0.
- Let E0 be the accepting edge.
  - busy=1 after E0 through E(WIDTH−1), for WIDTH cycles.
  - After E(WIDTH): state=DONE, done=1, busy=0, diff/borrow_out updated.
  - After E(WIDTH+1): done=0, IDLE.
  - Earliest next accept is E(WIDTH+2), so throughput is one op per WIDTH+2 cycles.
- busy and done are never high together.
- rst_n low in any state, including mid-RUN: immediate return to reset values, no done pulse, partial result discarded.
- Release of rst_n is synchronised externally. The block needs no extra handling.
- All outputs are registered, with no combinational input→output paths.

## Structure
- Shared package serial_sub_pkg:
  - State encoding localparams (IDLE=2'd0, RUN=2'd1, DONE=2'd2).
  - clog2 function used for the counter width.
- Sub-module full_sub_cell: one-bit full subtractor (a, b, bin → d, bout).
  - Built from two instances of the existing half-subtractor cell plus an OR of the two borrows.
  - Purely combinational.
- Controller FSM, counter, operand shift registers and result register live in serial_sub_ctrl.

## Test plan
- WIDTH=8, a=200, b=55, start one cycle → busy for 8 cycles; done 8 cycles after accept; diff=145, borrow_out=0.
- a=5, b=9 → diff=252, borrow_out=1. Then a=77, b=77 → diff=0, borrow_out=0.
- a=0, b=255 → diff=1, borrow_out=1. Change a/b every cycle during RUN → result unaffected.
- Pulse start at cycles 3 and 6 of a running op → ignored; exactly one done. Hold start high continuously → accepts every WIDTH+2 cycles.
- Assert rst_n low at RUN cycle 4 → all outputs 0 immediately, no done. After release, a=10, b=3 → diff=7.
- WIDTH=4, exhaustive 256 operand pairs against a reference model → diff and borrow_out match.
